// File: rtl/as6500_tdc_control.sv
// AS6500 TDC SPI sequencer: power-on reset, config write/verify, init,
// then one 12-byte result read per angle-sync rising edge in run mode.
//
// Ports:
//   i_clk_50m, i_rst      : system clock, synchronous active-high reset
//   i_angle_sync          : async angle pulse, rising edge requests a read
//   i_motor_state         : 1 = motor at speed, reads permitted
//   i_tdc_init            : level, 1 starts the configuration sequence
//   i_tdc_spi_miso        : SPI data from the TDC
//   o_tdc_spi_mosi/ssn/clk: SPI mode 1 master outputs
//   o_rise_data/fall_data : channel-1 / channel-2 stop results
//   o_tdc_err_sig         : config readback mismatch
//   o_tdc_new_sig         : one-cycle strobe, new rise/fall data valid
module as6500_tdc_control #(
    parameter int SPI_DIV = 2,
    parameter int CFG_NUM = 17,
    parameter int DATA_W  = 24
) (
    input  logic              i_clk_50m,
    input  logic              i_rst,
    input  logic              i_angle_sync,
    input  logic              i_motor_state,
    input  logic              i_tdc_init,
    input  logic              i_tdc_spi_miso,
    output logic              o_tdc_spi_mosi,
    output logic              o_tdc_spi_ssn,
    output logic              o_tdc_spi_clk,
    output logic [DATA_W-1:0] o_rise_data,
    output logic [DATA_W-1:0] o_fall_data,
    output logic              o_tdc_err_sig,
    output logic              o_tdc_new_sig
);

    typedef enum logic [2:0] {
        WAIT_INIT, POR, WR_CFG, VERIFY, INIT, IDLE, READ, DONE
    } state_t;

    typedef enum logic [2:0] {
        PH_IDLE, PH_LEAD, PH_HI, PH_LO, PH_TRAIL, PH_GAP
    } phase_t;

    localparam logic [8:0] DIV_END = 9'(SPI_DIV - 1);
    localparam logic [8:0] GAP_END = 9'(2 * SPI_DIV - 1);

    state_t      state;
    phase_t      phase;
    logic [8:0]  cnt;
    logic [2:0]  bit_cnt;
    logic [4:0]  byte_cnt;
    logic [7:0]  rx;
    logic [7:0]  tx_cur;
    logic [7:0]  tx_next;
    logic        match;
    logic        frame_state;
    logic        sync_rise;
    logic [2:0]  sync_q;
    logic [DATA_W-1:0] rise_buf;
    logic [DATA_W-1:0] fall_buf;

    function automatic logic [7:0] cfg_byte(input logic [4:0] a);
        logic [7:0] v;
        case (a)
            5'd0:    v = 8'h31;
            5'd1:    v = 8'h01;
            5'd2:    v = 8'h1F;
            5'd3:    v = 8'h40;
            5'd4:    v = 8'h0D;
            5'd5:    v = 8'h03;
            5'd6:    v = 8'hC0;
            5'd7:    v = 8'h53;
            5'd8:    v = 8'hA1;
            5'd9:    v = 8'h13;
            5'd10:   v = 8'h00;
            5'd11:   v = 8'h0A;
            5'd12:   v = 8'hCC;
            5'd13:   v = 8'hCC;
            5'd14:   v = 8'hF1;
            5'd15:   v = 8'h7D;
            5'd16:   v = 8'h04;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Byte idx of the frame issued in state st (idx 0 is the opcode).
    function automatic logic [7:0] tx_byte(input state_t st,
                                           input logic [4:0] idx);
        logic [7:0] v;
        case (st)
            POR:     v = 8'h30;
            WR_CFG:  v = (idx == 5'd0) ? 8'h80 : cfg_byte(idx - 5'd1);
            VERIFY:  v = (idx == 5'd0) ? 8'h40 : 8'h00;
            INIT:    v = 8'h18;
            READ:    v = (idx == 5'd0) ? 8'h68 : 8'h00;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [4:0] last_byte(input state_t st);
        logic [4:0] v;
        case (st)
            WR_CFG:  v = 5'(CFG_NUM);
            VERIFY:  v = 5'd1;
            READ:    v = 5'd12;
            default: v = 5'd0;
        endcase
        return v;
    endfunction

    assign tx_cur      = tx_byte(state, byte_cnt);
    assign tx_next     = tx_byte(state, byte_cnt + 5'd1);
    assign frame_state = (state == POR) || (state == WR_CFG) ||
                         (state == VERIFY) || (state == INIT) ||
                         (state == READ);
    assign sync_rise   = sync_q[1] & ~sync_q[2];

    always_ff @(posedge i_clk_50m) begin
        if (i_rst) sync_q <= 3'b000;
        else       sync_q <= {sync_q[1:0], i_angle_sync};
    end

    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            state          <= WAIT_INIT;
            phase          <= PH_IDLE;
            cnt            <= '0;
            bit_cnt        <= '0;
            byte_cnt       <= '0;
            rx             <= '0;
            match          <= 1'b0;
            rise_buf       <= '0;
            fall_buf       <= '0;
            o_tdc_spi_ssn  <= 1'b1;
            o_tdc_spi_clk  <= 1'b0;
            o_tdc_spi_mosi <= 1'b0;
            o_rise_data    <= '0;
            o_fall_data    <= '0;
            o_tdc_err_sig  <= 1'b0;
            o_tdc_new_sig  <= 1'b0;
        end else begin
            o_tdc_new_sig <= 1'b0;

            case (phase)
                PH_IDLE: begin
                    if (frame_state) begin
                        o_tdc_spi_ssn <= 1'b0;
                        phase         <= PH_LEAD;
                        cnt           <= '0;
                        bit_cnt       <= '0;
                        byte_cnt      <= '0;
                    end
                end
                PH_LEAD: begin
                    if (cnt == DIV_END) begin
                        cnt            <= '0;
                        o_tdc_spi_clk  <= 1'b1;
                        o_tdc_spi_mosi <= tx_cur[7];
                        phase          <= PH_HI;
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                PH_HI: begin
                    if (cnt == DIV_END) begin
                        cnt           <= '0;
                        o_tdc_spi_clk <= 1'b0;
                        rx            <= {rx[6:0], i_tdc_spi_miso};
                        phase         <= PH_LO;
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                PH_LO: begin
                    if (cnt == DIV_END) begin
                        cnt <= '0;
                        if (bit_cnt != 3'd7) begin
                            bit_cnt        <= bit_cnt + 3'd1;
                            o_tdc_spi_clk  <= 1'b1;
                            o_tdc_spi_mosi <= tx_cur[3'd6 - bit_cnt];
                            phase          <= PH_HI;
                        end else begin
                            // rx holds the byte just completed
                            if (state == VERIFY && byte_cnt == 5'd1)
                                match <= (rx == cfg_byte(5'd0));
                            if (state == READ && byte_cnt >= 5'd4 &&
                                byte_cnt <= 5'd6)
                                rise_buf <= {rise_buf[DATA_W-9:0], rx};
                            if (state == READ && byte_cnt >= 5'd10)
                                fall_buf <= {fall_buf[DATA_W-9:0], rx};
                            if (byte_cnt == last_byte(state)) begin
                                phase <= PH_TRAIL;
                            end else begin
                                byte_cnt       <= byte_cnt + 5'd1;
                                bit_cnt        <= '0;
                                o_tdc_spi_clk  <= 1'b1;
                                o_tdc_spi_mosi <= tx_next[7];
                                phase          <= PH_HI;
                            end
                        end
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                PH_TRAIL: begin
                    if (cnt == DIV_END) begin
                        cnt            <= '0;
                        o_tdc_spi_ssn  <= 1'b1;
                        o_tdc_spi_mosi <= 1'b0;
                        phase          <= PH_GAP;
                        case (state)
                            POR:    state <= WR_CFG;
                            WR_CFG: state <= VERIFY;
                            VERIFY: begin
                                o_tdc_err_sig <= ~match;
                                state         <= match ? INIT : POR;
                            end
                            INIT:   state <= IDLE;
                            READ: begin
                                o_rise_data   <= rise_buf;
                                o_fall_data   <= fall_buf;
                                o_tdc_new_sig <= 1'b1;
                                state         <= DONE;
                            end
                            default: state <= state;
                        endcase
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                PH_GAP: begin
                    // ssn stays high for 2*SPI_DIV cycles between frames
                    if (cnt == GAP_END) begin
                        cnt   <= '0;
                        phase <= PH_IDLE;
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                default: phase <= PH_IDLE;
            endcase

            case (state)
                WAIT_INIT: if (i_tdc_init) state <= POR;
                IDLE:      if (sync_rise && i_motor_state) state <= READ;
                DONE:      state <= IDLE;
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_as6500_tdc_control.sv
// Bench for as6500_tdc_control: SPI slave model with frame recorder,
// checks config sequence, verify retry, result reads and reset.
module tb_as6500_tdc_control;

    localparam int DIV = 2;
    localparam int CFG = 17;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        sync  = 1'b0;
    logic        motor = 1'b0;
    logic        init  = 1'b0;
    logic        miso  = 1'b0;
    logic        mosi;
    logic        ssn;
    logic        sclk;
    logic        err;
    logic        nsig;
    logic [23:0] rise;
    logic [23:0] fall;

    int checks   = 0;
    int failures = 0;

    as6500_tdc_control #(
        .SPI_DIV(DIV),
        .CFG_NUM(CFG),
        .DATA_W (24)
    ) dut (
        .i_clk_50m     (clk),
        .i_rst         (rst),
        .i_angle_sync  (sync),
        .i_motor_state (motor),
        .i_tdc_init    (init),
        .i_tdc_spi_miso(miso),
        .o_tdc_spi_mosi(mosi),
        .o_tdc_spi_ssn (ssn),
        .o_tdc_spi_clk (sclk),
        .o_rise_data   (rise),
        .o_fall_data   (fall),
        .o_tdc_err_sig (err),
        .o_tdc_new_sig (nsig)
    );

    always #10 clk = ~clk;

    logic [7:0] cfg_tab [0:16] = '{
        8'h31, 8'h01, 8'h1F, 8'h40, 8'h0D, 8'h03, 8'hC0, 8'h53, 8'hA1,
        8'h13, 8'h00, 8'h0A, 8'hCC, 8'hCC, 8'hF1, 8'h7D, 8'h04
    };

    // Recorded frames: bytes seen on MOSI, byte count, ssn-low cycles,
    // SCLK rise-to-rise period.
    logic [7:0] fmem [0:63][0:31];
    int         flen [0:63];
    int         flow [0:63];
    int         fper [0:63];
    int         nframes = 0;

    int         cyc       = 0;
    int         low_cnt   = 0;
    int         nb        = 0;
    int         bi        = 0;
    int         last_rise = -1;
    logic [7:0] cur       = 8'h00;
    logic [7:0] rb;
    logic       sclk_p    = 1'b0;
    logic       ssn_p     = 1'b1;

    logic [7:0] verify_val = 8'hFF;
    logic [7:0] rd [0:11];

    int          new_cnt   = 0;
    int          new_run   = 0;
    int          new_width = 0;
    logic [23:0] cap_rise  = 24'h0;
    logic [23:0] cap_fall  = 24'h0;

    // Slave response for byte idx of the frame in progress.
    function automatic logic [7:0] resp_byte(input int idx);
        if (idx == 0) return 8'h00;
        if (fmem[nframes][0] == 8'h40) return verify_val;
        if (idx <= 12) return rd[idx-1];
        return 8'h00;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (nsig) begin
            new_run++;
            cap_rise = rise;
            cap_fall = fall;
        end else if (new_run != 0) begin
            new_width = new_run;
            new_run   = 0;
            new_cnt++;
        end
        if (ssn_p && !ssn) begin
            low_cnt   = 0;
            nb        = 0;
            bi        = 0;
            last_rise = -1;
        end
        if (!ssn && nframes < 64) begin
            low_cnt++;
            if (sclk && !sclk_p) begin
                if (last_rise >= 0) fper[nframes] = cyc - last_rise;
                last_rise = cyc;
                rb   = resp_byte(bi / 8);
                miso = rb[7 - (bi % 8)];
                bi++;
            end
            if (!sclk && sclk_p) begin
                cur = {cur[6:0], mosi};
                nb++;
                if (nb % 8 == 0 && nb / 8 <= 32)
                    fmem[nframes][nb/8 - 1] = cur;
            end
        end
        if (!ssn_p && ssn && nframes < 64) begin
            flen[nframes] = nb / 8;
            flow[nframes] = low_cnt;
            nframes++;
        end
        sclk_p = sclk;
        ssn_p  = ssn;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int n, input string tag);
        for (int k = 0; k < 5000 && nframes < n; k++) @(negedge clk);
        chk(tag, 32'(nframes >= n), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_new(input int n, input string tag);
        for (int k = 0; k < 3000 && new_cnt < n; k++) @(negedge clk);
        chk(tag, 32'(new_cnt >= n), 32'd1);
    endtask

    task automatic pulse_sync();
        @(negedge clk);
        sync = 1'b1;
        repeat (4) @(negedge clk);
        sync = 1'b0;
    endtask

    task automatic do_read(input string tag);
        int n0;
        int c0;
        n0 = nframes;
        c0 = new_cnt;
        pulse_sync();
        wait_new(c0 + 1, {tag, "_done"});
        chk({tag, "_op"}, 32'(fmem[n0][0]), 32'h68);
        chk({tag, "_len"}, 32'(flen[n0]), 32'd13);
        chk({tag, "_rise"}, 32'(cap_rise), 32'({rd[3], rd[4], rd[5]}));
        chk({tag, "_fall"}, 32'(cap_fall), 32'({rd[9], rd[10], rd[11]}));
        chk({tag, "_strobe_w"}, 32'(new_width), 32'd1);
    endtask

    initial begin
        int n0;
        int c0;

        repeat (4) @(negedge clk);
        chk("rst_ssn", 32'(ssn), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_rise", 32'(rise), 32'd0);
        chk("rst_fall", 32'(fall), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_new", 32'(nsig), 32'd0);

        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("no_frame_wo_init", 32'(nframes), 32'd0);

        // First pass: readback 0xFF fails verification.
        init = 1'b1;
        wait_frames(3, "seq1_frames");
        chk("por_len", 32'(flen[0]), 32'd1);
        chk("por_byte", 32'(fmem[0][0]), 32'h30);
        chk("por_low", 32'(flow[0]), 32'(16 * DIV + 2 * DIV));
        chk("sclk_period", 32'(fper[0]), 32'(2 * DIV));
        chk("cfg_len", 32'(flen[1]), 32'(CFG + 1));
        chk("cfg_low", 32'(flow[1]), 32'((CFG + 1) * 16 * DIV + 2 * DIV));
        chk("cfg_op", 32'(fmem[1][0]), 32'h80);
        for (int i = 0; i < CFG; i++)
            chk($sformatf("cfg_b%0d", i), 32'(fmem[1][i+1]),
                32'(cfg_tab[i]));
        chk("ver_len", 32'(flen[2]), 32'd2);
        chk("ver_op", 32'(fmem[2][0]), 32'h40);
        chk("err_set", 32'(err), 32'd1);

        wait_frames(4, "retry_frame");
        chk("retry_por", 32'(fmem[3][0]), 32'h30);
        chk("err_held", 32'(err), 32'd1);

        // Second pass: readback matches; init level no longer matters.
        verify_val = 8'h31;
        init       = 1'b0;
        wait_frames(7, "seq2_frames");
        chk("retry_cfg", 32'(fmem[4][0]), 32'h80);
        chk("ver2_op", 32'(fmem[5][0]), 32'h40);
        chk("init_op", 32'(fmem[6][0]), 32'h18);
        chk("init_len", 32'(flen[6]), 32'd1);
        chk("err_clear", 32'(err), 32'd0);

        // Directed read with bytes 00..0B.
        motor = 1'b1;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 12; i++) rd[i] = 8'(i);
        do_read("rd_fixed");
        chk("rd_fixed_rise_abs", 32'(cap_rise), 32'h030405);
        chk("rd_fixed_fall_abs", 32'(cap_fall), 32'h090A0B);
        repeat (20) @(negedge clk);
        chk("hold_rise", 32'(rise), 32'h030405);
        chk("hold_fall", 32'(fall), 32'h090A0B);
        chk("strobe_low", 32'(nsig), 32'd0);

        // Motor stopped: sync is ignored.
        motor = 1'b0;
        n0 = nframes;
        c0 = new_cnt;
        pulse_sync();
        repeat (300) @(negedge clk);
        chk("motor0_no_frame", 32'(nframes), 32'(n0));
        chk("motor0_no_new", 32'(new_cnt), 32'(c0));
        motor = 1'b1;

        // Randomized result reads.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 12; i++) rd[i] = 8'($urandom_range(0, 255));
            do_read($sformatf("rd_rand%0d", r));
            repeat (10) @(negedge clk);
        end

        // A second sync during a read is not queued.
        for (int i = 0; i < 12; i++) rd[i] = 8'($urandom_range(0, 255));
        n0 = nframes;
        c0 = new_cnt;
        pulse_sync();
        repeat (100) @(negedge clk);
        chk("busy_ssn_low", 32'(ssn), 32'd0);
        pulse_sync();
        wait_new(c0 + 1, "busy_done");
        repeat (600) @(negedge clk);
        chk("busy_one_frame", 32'(nframes), 32'(n0 + 1));
        chk("busy_one_new", 32'(new_cnt), 32'(c0 + 1));
        chk("busy_rise", 32'(rise), 32'({rd[3], rd[4], rd[5]}));

        // Reset in the middle of a read.
        for (int i = 0; i < 12; i++) rd[i] = 8'($urandom_range(0, 255));
        pulse_sync();
        repeat (150) @(negedge clk);
        chk("mid_read_ssn", 32'(ssn), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_ssn", 32'(ssn), 32'd1);
        chk("mrst_sclk", 32'(sclk), 32'd0);
        chk("mrst_rise", 32'(rise), 32'd0);
        chk("mrst_fall", 32'(fall), 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        chk("mrst_new", 32'(nsig), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n0 = nframes;
        repeat (200) @(negedge clk);
        chk("mrst_wait_init", 32'(nframes), 32'(n0));
        init = 1'b1;
        wait_frames(n0 + 1, "mrst_restart");
        chk("mrst_por", 32'(fmem[n0][0]), 32'h30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
